// File: rtl/mem_read_write_ctrl.sv
// ---------------------------------------------------------------------------
// mem_read_write_ctrl
//
// Memory access controller placed directly upstream of the MDR. It owns a
// word-addressed synchronous RAM and serves single-word read/write requests
// from the control unit. A read completes by driving Mdatain and strobing the
// MDR (mdr_read selects Mdatain, mdr_load loads it), so the control unit only
// has to issue the request and wait for done. WAIT_CYCLES models slow memory.
//
// Parameters:
//   DATA_W      word width, must match the MDR width
//   ADDR_W      address width, RAM depth = 2**ADDR_W words
//   WAIT_CYCLES extra access cycles before read data is valid or a write
//               commits (0..15)
//
// Ports:
//   clk      in   system clock, rising edge
//   clr      in   asynchronous active-low reset
//   rd_req   in   read request, sampled only in IDLE (wins over wr_req)
//   wr_req   in   write request, sampled only in IDLE
//   addr     in   word address from the MAR
//   wdata    in   write data from the MDR
//   Mdatain  out  registered read data toward the MDR mux
//   mdr_read out  MDR mux select, 1 = take Mdatain (RD_LOAD only)
//   mdr_load out  MDRin strobe (RD_LOAD only)
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module mem_read_write_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mdr_read,
    output logic              mdr_load,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    // Counter value loaded on entry to a wait state; unused when ZERO_WAIT.
    localparam logic [3:0] CNT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_LOAD = 3'd2,
        WR_WAIT = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mdatain_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                rd_accept;
    logic                wr_accept;
    logic                rd_fire;
    logic                mem_we;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    // Request decode in IDLE: read has priority, a simultaneous write is dropped.
    assign rd_accept = (state_q == IDLE) && rd_req;
    assign wr_accept = (state_q == IDLE) && wr_req && !rd_req;

    // With no wait states the RAM access happens on the accept edge itself,
    // so the live address/data are used instead of the latched copies.
    assign rd_fire = ZERO_WAIT ? rd_accept
                               : ((state_q == RD_WAIT) && (cnt_q == 4'd0));
    assign rd_addr = ZERO_WAIT ? addr : addr_q;

    // Gating with clr keeps a request seen during reset from touching the RAM.
    assign mem_we  = clr && (ZERO_WAIT ? wr_accept
                                       : ((state_q == WR_WAIT) && (cnt_q == 4'd0)));
    assign wr_addr = ZERO_WAIT ? addr  : addr_q;
    assign wr_data = ZERO_WAIT ? wdata : wdata_q;

    // -----------------------------------------------------------------------
    // FSM process 1: state and wait counter registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state and counter logic.
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = ZERO_WAIT ? RD_LOAD : RD_WAIT;
                    cnt_d   = CNT_INIT;
                end else if (wr_req) begin
                    state_d = ZERO_WAIT ? DONE : WR_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RD_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_LOAD: state_d = DONE;
            WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs decoded purely from state.
    // -----------------------------------------------------------------------
    always_comb begin
        mdr_read = 1'b0;
        mdr_load = 1'b0;
        busy     = (state_q != IDLE);
        done     = 1'b0;
        unique case (state_q)
            RD_LOAD: begin
                mdr_read = 1'b1;
                mdr_load = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Request capture: addr/wdata may change freely after the accept edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (rd_accept || wr_accept) begin
                addr_q <= addr;
            end
            if (wr_accept) begin
                wdata_q <= wdata;
            end
        end
    end

    // Read data register: holds the last read word; writes never update it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mdatain_q <= '0;
        end else if (rd_fire) begin
            mdatain_q <= mem_q[rd_addr];
        end
    end

    // NOTE: the RAM array has no reset branch; clearing it would prevent block
    // RAM inference and contents are expected to survive a controller reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign Mdatain = mdatain_q;

endmodule

// File: tb/tb_mem_read_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_read_write_ctrl
//
// Directed bench for mem_read_write_ctrl. Two instances share clk and clr:
// dut_a with WAIT_CYCLES = 2 and dut_b with WAIT_CYCLES = 0. Inputs are
// driven on the falling edge, outputs sampled 1 time unit after the rising
// edge. Latency is counted in cycles after the accept edge: the first
// sample after the accept edge is cycle 1.
// ---------------------------------------------------------------------------
module tb_mem_read_write_ctrl;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          clr;

    logic          rd_req_a, wr_req_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a;
    logic [DW-1:0] mdatain_a;
    logic          mdr_read_a, mdr_load_a, busy_a, done_a;

    logic          rd_req_b, wr_req_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b;
    logic [DW-1:0] mdatain_b;
    logic          mdr_read_b, mdr_load_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_read_write_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .clr(clr), .rd_req(rd_req_a), .wr_req(wr_req_a),
        .addr(addr_a), .wdata(wdata_a), .Mdatain(mdatain_a),
        .mdr_read(mdr_read_a), .mdr_load(mdr_load_a), .busy(busy_a), .done(done_a)
    );

    mem_read_write_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .clr(clr), .rd_req(rd_req_b), .wr_req(wr_req_b),
        .addr(addr_b), .wdata(wdata_b), .Mdatain(mdatain_b),
        .mdr_read(mdr_read_b), .mdr_load(mdr_load_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request on instance a (sel=0) or b (sel=1) and follows it to
    // done. Returns latency (-1 on timeout), number of mdr_load cycles, the
    // cycle of the last mdr_load, Mdatain seen during mdr_load, whether
    // mdr_read tracked mdr_load, and whether busy stayed high until done.
    // poke injects a write to 0x020 while the op is in progress.
    task automatic do_op(input bit sel, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit poke,
                         output int lat, output int loads, output int load_cyc,
                         output logic [DW-1:0] md, output bit rd_ok,
                         output bit busy_ok);
        int cyc;
        lat = -1; loads = 0; load_cyc = 0; md = '0; rd_ok = 1'b1; busy_ok = 1'b1;
        @(negedge clk);
        if (sel) begin rd_req_b = rd; wr_req_b = wr; addr_b = a; wdata_b = d; end
        else     begin rd_req_a = rd; wr_req_a = wr; addr_a = a; wdata_a = d; end
        @(posedge clk); #1;
        // Scramble the bus after accept: it must have no effect.
        if (sel) begin rd_req_b = 0; wr_req_b = 0; addr_b = AW'($urandom); wdata_b = $urandom; end
        else     begin rd_req_a = 0; wr_req_a = 0; addr_a = AW'($urandom); wdata_a = $urandom; end
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (poke && !sel) begin
                if (cyc == 1) begin wr_req_a = 1; addr_a = 9'h020; wdata_a = 32'hFFFF0000; end
                if (cyc == 3) wr_req_a = 0;
            end
            if ((sel ? mdr_load_b : mdr_load_a) === 1'b1) begin
                loads++;
                load_cyc = cyc;
                md = sel ? mdatain_b : mdatain_a;
            end
            if ((sel ? mdr_read_b : mdr_read_a) !== (sel ? mdr_load_b : mdr_load_a)) rd_ok = 1'b0;
            if ((sel ? busy_b : busy_a) !== 1'b1) busy_ok = 1'b0;
            if ((sel ? done_b : done_a) === 1'b1) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;  // DONE -> IDLE
        if (!poke || sel) begin
            if (sel) check("idle_busy_b", busy_b, 0);
            else     check("idle_busy_a", busy_a, 0);
        end
    endtask

    int            lat, loads, lcyc;
    logic [DW-1:0] md;
    bit            rd_ok, busy_ok;
    int            done_seen;

    initial begin
        clr = 1'b0;
        rd_req_a = 0; wr_req_a = 0; addr_a = '0; wdata_a = '0;
        rd_req_b = 0; wr_req_b = 0; addr_b = '0; wdata_b = '0;

        // ---- Reset with inputs toggling ----
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd_req_a = 1'($urandom); wr_req_a = 1'($urandom);
            addr_a = AW'($urandom); wdata_a = $urandom;
            rd_req_b = 1'($urandom); wr_req_b = 1'($urandom);
            addr_b = AW'($urandom); wdata_b = $urandom;
            @(posedge clk); #1;
            check("rst_mdatain", mdatain_a, 0);
            check("rst_mdr_read", mdr_read_a, 0);
            check("rst_mdr_load", mdr_load_a, 0);
            check("rst_busy", busy_a, 0);
            check("rst_done", done_a, 0);
            check("rst_busy_b", busy_b, 0);
            check("rst_mdatain_b", mdatain_b, 0);
        end
        @(negedge clk);
        rd_req_a = 0; wr_req_a = 0; rd_req_b = 0; wr_req_b = 0;
        clr = 1'b1;

        // ---- Write then read, WAIT_CYCLES = 2 ----
        do_op(0, 0, 1, 9'h005, 32'hDEADBEEF, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("wr005_lat", lat, 3);
        check("wr005_loads", loads, 0);
        check("wr005_busy", busy_ok, 1);
        check("wr_keeps_mdatain", mdatain_a, 0);
        do_op(0, 1, 0, 9'h005, 32'h0, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("rd005_lat", lat, 4);
        check("rd005_loads", loads, 1);
        check("rd005_load_cyc", lcyc, 3);
        check("rd005_data", md, 32'hDEADBEEF);
        check("rd005_read_eq_load", rd_ok, 1);
        check("rd005_hold", mdatain_a, 32'hDEADBEEF);

        // ---- Simultaneous requests: read wins, write dropped ----
        do_op(0, 0, 1, 9'h010, 32'h12345678, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("wr010_lat", lat, 3);
        check("wr_after_rd_keeps_mdatain", mdatain_a, 32'hDEADBEEF);
        do_op(0, 1, 1, 9'h010, 32'hFFFFFFFF, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("both_lat", lat, 4);
        check("both_data", md, 32'h12345678);
        do_op(0, 1, 0, 9'h010, 32'h0, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("rd010_again", md, 32'h12345678);

        // ---- Requests ignored while busy ----
        do_op(0, 0, 1, 9'h020, 32'hA5A5A5A5, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("wr020_lat", lat, 3);
        do_op(0, 1, 0, 9'h005, 32'h0, 1, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("poke_lat", lat, 4);
        check("poke_busy_held", busy_ok, 1);
        check("poke_data", md, 32'hDEADBEEF);
        check("poke_idle_busy", busy_a, 0);
        do_op(0, 1, 0, 9'h020, 32'h0, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("rd020_unchanged", md, 32'hA5A5A5A5);

        // ---- Reset during WR_WAIT ----
        do_op(0, 0, 1, 9'h030, 32'h11112222, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("wr030_lat", lat, 3);
        @(negedge clk);
        wr_req_a = 1; addr_a = 9'h030; wdata_a = 32'hCAFEF00D;
        @(posedge clk); #1;
        wr_req_a = 0;
        check("midwr_busy", busy_a, 1);
        #2 clr = 1'b0;
        #1;
        check("midwr_rst_busy", busy_a, 0);
        check("midwr_rst_done", done_a, 0);
        check("midwr_rst_mdatain", mdatain_a, 0);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done_a === 1'b1 || busy_a === 1'b1) done_seen++;
        end
        check("midwr_no_done", done_seen, 0);
        do_op(0, 1, 0, 9'h030, 32'h0, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("rd030_old", md, 32'h11112222);

        // ---- WAIT_CYCLES = 0 instance ----
        do_op(1, 0, 1, 9'h1FF, 32'h00000001, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("b_wr1ff_lat", lat, 1);
        do_op(1, 0, 1, 9'h000, 32'hABCD0000, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("b_wr000_lat", lat, 1);
        do_op(1, 1, 0, 9'h1FF, 32'h0, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("b_rd1ff_lat", lat, 2);
        check("b_rd1ff_load_cyc", lcyc, 1);
        check("b_rd1ff_loads", loads, 1);
        check("b_rd1ff_data", md, 32'h00000001);
        check("b_rd1ff_read_eq_load", rd_ok, 1);
        do_op(1, 1, 0, 9'h000, 32'h0, 0, lat, loads, lcyc, md, rd_ok, busy_ok);
        check("b_rd000_data", md, 32'hABCD0000);
        check("b_rd000_hold", mdatain_b, 32'hABCD0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_read_write_ctrl.md
Name: mem_read_write_ctrl

Overview:
- Memory access controller sitting directly upstream of the MDR.
- Owns a word-addressed synchronous RAM. Accepts single-word read/write requests from the control unit, using the address latched from MAR and write data from the MDR output.
- On reads it drives Mdatain and generates the MDR strobes (read = select Mdatain, MDRin = load) so the MDR captures memory data with no control-unit involvement.
- Programmable wait states model slow memory; busy/done form the handshake back to the control unit.

Parameters:
- DATA_W, 32, word width; must match MDR width.
- ADDR_W, 9, address width; RAM depth = 2^ADDR_W words.
- WAIT_CYCLES, 2, extra access cycles before data is valid or a write commits; legal range 0..15.

Ports:
- clk  in  1  system clock, rising-edge.
- clr  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request; sampled only in IDLE.
- wr_req  in  1  write request; sampled only in IDLE.
- addr  in  ADDR_W  word address (MAR output).
- wdata  in  DATA_W  write data (MDR q).
- Mdatain  out  DATA_W  registered read data toward the MDR mux.
- mdr_read  out  1  MDR mux select; 1 = take Mdatain.
- mdr_load  out  1  MDRin strobe to the MDR.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (clr low, asynchronous):
  - state = IDLE.
  - Mdatain = 0; mdr_read, mdr_load, busy, done = 0.
  - Wait counter = 0.
  - RAM contents are not cleared.
- States: IDLE, RD_WAIT, RD_LOAD, WR_WAIT, DONE.
- IDLE, request accept:
  - On a clk edge with rd_req = 1, latch addr and go to RD_WAIT, or to RD_LOAD directly if WAIT_CYCLES = 0.
  - On wr_req = 1 (rd_req = 0), latch addr and wdata and go to WR_WAIT, or commit the write immediately and go to DONE if WAIT_CYCLES = 0.
  - rd_req and wr_req both high: read wins; the write is dropped (not queued).
  - Entering a wait state loads counter = WAIT_CYCLES - 1.
- RD_WAIT:
  - Counter decrements each cycle.
  - On the edge where counter = 0: Mdatain <= RAM[latched addr], then go to RD_LOAD.
  - For WAIT_CYCLES = 0 the RAM read happens on the accept edge.
- RD_LOAD (exactly one cycle):
  - mdr_read = 1 and mdr_load = 1, both decoded combinationally from state.
  - The MDR captures Mdatain on the closing edge.
  - Next state DONE.
- WR_WAIT:
  - Counter decrements each cycle.
  - On the edge where counter = 0: RAM[latched addr] <= latched wdata, then go to DONE.
- DONE (exactly one cycle): done = 1; next state IDLE.
- Latency, request edge to done high:
  - Read: WAIT_CYCLES + 2 cycles.
  - Write: WAIT_CYCLES + 1 cycles.
  - A new request may be accepted on the edge that leaves DONE? No: DONE always returns to IDLE, and sampling happens there. Back-to-back throughput is one op per (latency + 1) cycles.
- Requests are ignored outside IDLE. addr and wdata may change after the accept edge without effect.
- mdr_read and mdr_load are 0 in all states except RD_LOAD.
- Mdatain holds its last read value until the next read; writes do not update it.
- Write then read of the same address returns the new data.
- Address wrap: addr is exactly ADDR_W bits, so no out-of-range case exists.
- Reset mid-operation: the FSM aborts to IDLE. A pending write is not committed; a pending read does not pulse mdr_load. Mdatain returns to 0.

Test Plan:
- Reset: clr = 0 with random inputs toggling -> all outputs 0, busy 0.
- Write then read, WAIT_CYCLES = 2: write 0xDEADBEEF to addr 0x005, then read addr 0x005.
  - Write: done 3 cycles after accept.
  - Read: mdr_load/mdr_read high exactly one cycle, Mdatain = 0xDEADBEEF, done 4 cycles after accept.
- Simultaneous requests: rd_req = wr_req = 1 at addr 0x010 (previously holding 0x12345678), wdata = 0xFFFFFFFF.
  - Read occurs and Mdatain = 0x12345678.
  - A later read of 0x010 still returns 0x12345678.
- Busy ignore: assert wr_req to addr 0x020 while a read is in RD_WAIT -> no write occurs, RAM[0x020] unchanged, busy stays 1 until DONE exits.
- Reset mid-write: clr pulsed low during WR_WAIT of 0xCAFEF00D to 0x030 -> RAM[0x030] keeps its old value, state IDLE, done never pulses.
- WAIT_CYCLES = 0 build: read of addr 0x1FF (holding 0x00000001) -> RD_LOAD on the cycle after accept, done 2 cycles after accept; addresses 0x000 and 0x1FF accessed independently.
